// File: rtl/strob_seq_if.sv
// Handshake bundle between the cycle sequencer and the P-M microinstruction unit.
interface strob_seq_if;
  // Next-state enables and cycle control from P-M
  logic ep0, ek1, ek2, ep1, ep2, ep3, ep4, ep5;
  logic stp0;
  logic hold;
  // One-hot processor state and strobe phases to P-M
  logic k1, k2, p0, p1, p2, p3, p4, p5;
  logic strob1, strob2, got, idle;

  modport master (
    input  ep0, ek1, ek2, ep1, ep2, ep3, ep4, ep5, stp0, hold,
    output k1, k2, p0, p1, p2, p3, p4, p5, strob1, strob2, got, idle
  );

  modport slave (
    output ep0, ek1, ek2, ep1, ep2, ep3, ep4, ep5, stp0, hold,
    input  k1, k2, p0, p1, p2, p3, p4, p5, strob1, strob2, got, idle
  );
endinterface

// File: rtl/strob_seq.sv
// Cycle sequencer: one-hot processor state plus STROB1 -> STROB2 -> GOT phase generator.
module strob_seq #(
  parameter int unsigned S1_LEN    = 2,
  parameter int unsigned S2_LEN    = 2,
  parameter logic [7:0]  LONG_MASK = 8'b0011_1011
) (
  input  logic       clk,
  input  logic       clm,
  strob_seq_if.master bus
);

  // State bit positions: [0]K1 [1]K2 [2]P0 [3]P1 [4]P2 [5]P3 [6]P4 [7]P5
  localparam logic [7:0] StP0 = 8'b0000_0100;
  localparam logic [3:0] S1Load = 4'(S1_LEN - 1);
  localparam logic [3:0] S2Load = 4'(S2_LEN - 1);

  typedef enum logic [1:0] {PhIdle, PhSt1, PhSt2, PhGot} phase_e;

  phase_e      phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  state_q, state_d;
  logic [7:0]  nxt_state;
  logic        long_cycle;
  logic        strob1_q, strob2_q, got_q, idle_q;

  assign long_cycle = |(state_q & LONG_MASK);

  // Fixed-priority next-state selection: ep0 > ek1 > ek2 > ep1 > ... > ep5, default P0
  always_comb begin
    nxt_state = StP0;
    if      (bus.ep0) nxt_state = 8'b0000_0100;
    else if (bus.ek1) nxt_state = 8'b0000_0001;
    else if (bus.ek2) nxt_state = 8'b0000_0010;
    else if (bus.ep1) nxt_state = 8'b0000_1000;
    else if (bus.ep2) nxt_state = 8'b0001_0000;
    else if (bus.ep3) nxt_state = 8'b0010_0000;
    else if (bus.ep4) nxt_state = 8'b0100_0000;
    else if (bus.ep5) nxt_state = 8'b1000_0000;
  end

  // Phase FSM next-state; hold freezes counter, phase and state alike
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!bus.hold) begin
      unique case (phase_q)
        PhIdle: begin
          if (bus.stp0) begin
            phase_d = PhSt1;
            cnt_d   = S1Load;
          end
        end
        PhSt1: begin
          if (cnt_q == 4'd0) begin
            if (long_cycle) begin
              phase_d = PhSt2;
              cnt_d   = S2Load;
            end else begin
              phase_d = PhGot;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        PhSt2: begin
          if (cnt_q == 4'd0) phase_d = PhGot;
          else               cnt_d   = cnt_q - 4'd1;
        end
        PhGot: begin
          // State register only moves here, so P-M sees it stable for the whole cycle
          state_d = nxt_state;
          if (nxt_state == StP0 && !bus.stp0) begin
            phase_d = PhIdle;
            cnt_d   = 4'd0;
          end else begin
            phase_d = PhSt1;
            cnt_d   = S1Load;
          end
        end
        default: phase_d = PhIdle;
      endcase
    end
  end

  // State, phase and registered strobe decodes; clm aborts the cycle at once
  always_ff @(posedge clk or posedge clm) begin
    if (clm) begin
      phase_q  <= PhIdle;
      cnt_q    <= 4'd0;
      state_q  <= StP0;
      strob1_q <= 1'b0;
      strob2_q <= 1'b0;
      got_q    <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      strob1_q <= (phase_d == PhSt1);
      strob2_q <= (phase_d == PhSt2);
      got_q    <= (phase_d == PhGot);
      idle_q   <= (phase_d == PhIdle);
    end
  end

  assign bus.k1     = state_q[0];
  assign bus.k2     = state_q[1];
  assign bus.p0     = state_q[2];
  assign bus.p1     = state_q[3];
  assign bus.p2     = state_q[4];
  assign bus.p3     = state_q[5];
  assign bus.p4     = state_q[6];
  assign bus.p5     = state_q[7];
  assign bus.strob1 = strob1_q;
  assign bus.strob2 = strob2_q;
  assign bus.got    = got_q;
  assign bus.idle   = idle_q;

endmodule

// File: tb/tb_strob_seq.sv
// Directed and randomized self-checking bench for strob_seq.
module tb_strob_seq;

  // State vectors, bit order [0]K1 [1]K2 [2]P0 [3]P1 [4]P2 [5]P3 [6]P4 [7]P5
  localparam logic [7:0] K1 = 8'b0000_0001;
  localparam logic [7:0] K2 = 8'b0000_0010;
  localparam logic [7:0] P0 = 8'b0000_0100;
  localparam logic [7:0] P1 = 8'b0000_1000;
  localparam logic [7:0] P2 = 8'b0001_0000;
  localparam logic [7:0] P3 = 8'b0010_0000;
  localparam logic [7:0] P5 = 8'b1000_0000;
  // Phase outputs {strob1, strob2, got, idle}
  localparam logic [3:0] ST1  = 4'b1000;
  localparam logic [3:0] ST2  = 4'b0100;
  localparam logic [3:0] GOT  = 4'b0010;
  localparam logic [3:0] IDLE = 4'b0001;

  logic clk;
  logic clm;
  int   checks;
  int   failures;

  strob_seq_if bus ();

  strob_seq #(
    .S1_LEN   (2),
    .S2_LEN   (2),
    .LONG_MASK(8'b0011_1011)
  ) dut (
    .clk(clk),
    .clm(clm),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0, bus.k2, bus.k1,
            bus.strob1, bus.strob2, bus.got, bus.idle};
  endfunction

  task automatic check(input string tag, input logic [7:0] st, input logic [3:0] ph);
    logic [11:0] obs;
    obs = observed();
    checks++;
    assert (obs === {st, ph})
    else begin
      failures++;
      $error("FAIL %s: observed state=%b phase=%b expected state=%b phase=%b",
             tag, obs[11:4], obs[3:0], st, ph);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current clock, then advance; repeated n times
  task automatic expect_n(input string tag, input int n, input logic [7:0] st,
                          input logic [3:0] ph);
    for (int i = 0; i < n; i++) begin
      check(tag, st, ph);
      tick();
    end
  endtask

  task automatic clear_en();
    bus.ep0 = 0; bus.ek1 = 0; bus.ek2 = 0; bus.ep1 = 0;
    bus.ep2 = 0; bus.ep3 = 0; bus.ep4 = 0; bus.ep5 = 0;
  endtask

  initial begin
    logic [7:0] st_prev;
    logic       got_prev, hold_prev;
    logic [7:0] st_now;

    checks   = 0;
    failures = 0;
    clm      = 1'b0;
    clear_en();
    bus.stp0 = 0;
    bus.hold = 0;

    // Asynchronous reset, observed before any clock edge
    #2 clm = 1'b1;
    #1 check("reset", P0, IDLE);
    tick();
    clm = 1'b0;

    // Park in P0 with stp0 low, then start
    expect_n("idle_park", 10, P0, IDLE);
    bus.stp0 = 1;
    expect_n("idle_go", 1, P0, IDLE);
    bus.stp0 = 0;
    bus.ep1  = 1;
    // P0 is short: strob1 x2, got x1
    expect_n("p0_s1", 2, P0, ST1);
    expect_n("p0_got", 1, P0, GOT);

    // P1 long; an enable pulse during ST1 must be ignored
    clear_en();
    bus.ep3 = 1;
    expect_n("p1_s1", 2, P1, ST1);
    bus.ep3 = 0;
    bus.ep2 = 1;
    expect_n("p1_s2", 2, P1, ST2);
    expect_n("p1_got", 1, P1, GOT);

    // P2 long; ep0 beats ep3, stp0 low -> IDLE
    expect_n("p2_s1", 2, P2, ST1);
    expect_n("p2_s2", 2, P2, ST2);
    clear_en();
    bus.ep0 = 1;
    bus.ep3 = 1;
    expect_n("p2_got", 1, P2, GOT);
    clear_en();
    expect_n("prio_idle", 2, P0, IDLE);

    // Restart, ep3 beats ep5 -> P3
    bus.stp0 = 1;
    expect_n("idle_go2", 1, P0, IDLE);
    bus.stp0 = 0;
    bus.ep3  = 1;
    bus.ep5  = 1;
    expect_n("p0b_s1", 2, P0, ST1);
    expect_n("p0b_got", 1, P0, GOT);

    // P3 long with hold in ST2 (strob2 5 clocks) and in GOT (got 3 clocks); ek2 beats ep4
    clear_en();
    bus.ek2 = 1;
    bus.ep4 = 1;
    expect_n("p3_s1", 2, P3, ST1);
    expect_n("p3_s2a", 1, P3, ST2);
    bus.hold = 1;
    expect_n("p3_s2hold", 3, P3, ST2);
    bus.hold = 0;
    expect_n("p3_s2b", 1, P3, ST2);
    bus.hold = 1;
    expect_n("p3_gothold", 2, P3, GOT);
    bus.hold = 0;
    expect_n("p3_got", 1, P3, GOT);
    clear_en();

    // K2 long; clm in the middle of ST2 aborts immediately
    expect_n("k2_s1", 2, K2, ST1);
    expect_n("k2_s2", 1, K2, ST2);
    #2 clm = 1'b1;
    #1 check("clm_abort", P0, IDLE);
    tick();
    clm = 1'b0;
    expect_n("clm_idle", 3, P0, IDLE);

    // Restart, ek1 -> K1 (long), then no enables with stp0 high -> P0 ST1 with no gap
    bus.stp0 = 1;
    expect_n("idle_go3", 1, P0, IDLE);
    bus.stp0 = 0;
    bus.ek1  = 1;
    expect_n("p0c_s1", 2, P0, ST1);
    expect_n("p0c_got", 1, P0, GOT);
    clear_en();
    expect_n("k1_s1", 2, K1, ST1);
    expect_n("k1_s2", 2, K1, ST2);
    bus.stp0 = 1;
    expect_n("k1_got", 1, K1, GOT);
    bus.stp0 = 0;
    bus.ep5  = 1;
    expect_n("p0d_s1", 2, P0, ST1);
    expect_n("p0d_got", 1, P0, GOT);
    clear_en();
    // P5 short, then back to P0 idle
    expect_n("p5_s1", 2, P5, ST1);
    expect_n("p5_got", 1, P5, GOT);
    expect_n("end_idle", 1, P0, IDLE);

    // Random run: one-hot state, exclusive strobes, state moves only on an unheld GOT edge
    st_prev   = {bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0, bus.k2, bus.k1};
    got_prev  = bus.got;
    hold_prev = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      {bus.ep0, bus.ek1, bus.ek2, bus.ep1, bus.ep2, bus.ep3, bus.ep4, bus.ep5} =
        8'($urandom_range(0, 255));
      bus.stp0  = ($urandom_range(0, 3) != 0);
      bus.hold  = ($urandom_range(0, 3) == 0);
      hold_prev = bus.hold;
      tick();
      st_now = {bus.p5, bus.p4, bus.p3, bus.p2, bus.p1, bus.p0, bus.k2, bus.k1};
      checks++;
      assert ($onehot(st_now) && ($countones({bus.strob1, bus.strob2, bus.got}) <= 1)
              && (!bus.idle || bus.p0))
      else begin
        failures++;
        $error("FAIL rnd_invariant: observed state=%b s1=%b s2=%b got=%b idle=%b expected one-hot, exclusive",
               st_now, bus.strob1, bus.strob2, bus.got, bus.idle);
      end
      checks++;
      assert ((st_now === st_prev) || (got_prev && !hold_prev))
      else begin
        failures++;
        $error("FAIL rnd_state_edge: observed change %b->%b with got=%b hold=%b expected unheld got",
               st_prev, st_now, got_prev, hold_prev);
      end
      st_prev  = st_now;
      got_prev = bus.got;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
